// File: rtl/mult8_rr_sched_if.sv
// rtl/mult8_rr_sched_if.sv - request/response bundle between requesters and the mult8 front end
//
// Purpose: groups the two operand request channels, the single product
// response channel and the busy flag of mult8_rr_sched.
//
// Signals:
//   req0_valid/req0_ready/req0_a/req0_b : requester 0 operand handshake
//   req1_valid/req1_ready/req1_a/req1_b : requester 1 operand handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_prod : product response with backpressure
//   busy                                : engine not idle
//
// Modports:
//   master : requesting/consuming side (drives valids, operands, rsp_ready)
//   slave  : the mult8_rr_sched block

interface mult8_rr_sched_if #(
    parameter int WIDTH = 8
);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;

    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [2*WIDTH-1:0]     rsp_prod;

    logic                   busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        output rsp_ready,
        input  rsp_valid, rsp_id, rsp_prod,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        input  rsp_ready,
        output rsp_valid, rsp_id, rsp_prod,
        output busy
    );
endinterface

// File: rtl/mult8_rr_sched.sv
// rtl/mult8_rr_sched.sv - two-requester round-robin front end with shift-add multiplier engine
//
// Purpose: arbitrates two operand requesters onto one unsigned shift-add
// multiplier (one iteration per clock) and returns each product with the
// owning requester id on a single backpressured response channel.
//
// Ports:
//   clk  : system clock, rising edge
//   sig  : asynchronous active-high reset/clear
//   bus  : mult8_rr_sched_if.slave
//            req0_*/req1_* operand handshakes (ready combinational, IDLE only)
//            rsp_* product response, held stable until rsp_valid & rsp_ready
//            busy  high whenever the FSM is not IDLE
//
// Optional build macro:
//   MULT_ZERO_SKIP_EN : when defined, a request with a zero operand skips the
//                       shift iterations and goes straight to DONE with a
//                       zero product.

module mult8_rr_sched #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              sig,
    mult8_rr_sched_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [WIDTH-1:0]       r_acc;
    logic [WIDTH-1:0]       r_q;
    logic [WIDTH-1:0]       r_m;
    logic [CW-1:0]          r_count;
    logic                   r_id;
    logic                   r_ptr;
    logic [2*WIDTH-1:0]     r_prod;

    logic                   w_idle;
    logic                   w_grant;
    logic                   w_accept;
    logic                   w_zero;
    logic                   w_last;
    logic [WIDTH-1:0]       w_sel_a;
    logic [WIDTH-1:0]       w_sel_b;
    logic [WIDTH-1:0]       w_addend;
    logic [WIDTH:0]         w_sum;

    // ------------------------------------------------------------------
    // Arbitration: a lone valid wins; on contention the requester that
    // did not win last time wins. r_ptr holds the last granted id and
    // resets to 1 so requester 0 wins the first contention.
    // ------------------------------------------------------------------
    assign w_idle   = (r_state == ST_IDLE);
    assign w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_ptr : bus.req1_valid;
    assign w_accept = w_idle && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = w_idle && bus.req0_valid && !w_grant;
    assign bus.req1_ready = w_idle && bus.req1_valid &&  w_grant;

    assign w_sel_a = w_grant ? bus.req1_a : bus.req0_a;
    assign w_sel_b = w_grant ? bus.req1_b : bus.req0_b;

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero = (w_sel_a == '0) || (w_sel_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shift-add iteration: the sum is one bit wider than acc so the carry
    // out of the add is shifted into acc[WIDTH-1] rather than lost.
    // ------------------------------------------------------------------
    assign w_addend = r_q[0] ? r_m : '0;
    assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_last   = (r_count == CW'(WIDTH - 1));

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge sig) begin
        if (sig) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and arbitration state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge sig) begin
        if (sig) begin
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_count <= '0;
            r_id    <= 1'b0;
            r_ptr   <= 1'b1;
            r_prod  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Operands are sampled only here; later changes on
                        // the request inputs have no effect.
                        r_m     <= w_sel_a;
                        r_q     <= w_sel_b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_id    <= w_grant;
                        r_ptr   <= w_grant;
                        if (w_zero) begin
                            r_prod <= '0;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= w_sum[WIDTH:1];
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        // Product is the post-shift {acc,q} of the final iteration.
                        r_prod <= {w_sum[WIDTH:1], w_sum[0], r_q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_id    = r_id;
    assign bus.rsp_prod  = r_prod;
    assign bus.busy      = !w_idle;

endmodule
